instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Instruction fetch stage, directly upstream of the 128x32 instruction memory.
//  - Holds the PC and drives the memory word address; the memory returns the
//    word combinationally, in the same cycle.
//  - Buffers fetched words in a small FIFO and hands {pc, instr} to decode over
//    a valid/ready handshake.
//  - Accepts branch/jump redirects that flush all in-flight fetches.
// PARAMETERS
//  RESET_PC    32'h0  byte address of the first fetch after reset
//  ADDR_W      7      memory word-address width (128 entries)
//  FIFO_DEPTH  2      fetch buffer entries; any power of two >= 2
// PORTS
//  clk             in   1       rising-edge clock, the only clock
//  reset           in   1       asynchronous, active-high reset
//  fetch_en        in   1       1 = fetching allowed; 0 = PC frozen, FIFO drains
//  mem_addr        out  ADDR_W  word address to memory = pc[ADDR_W+1:2]
//  mem_data        in   32      word read from memory at mem_addr, same cycle
//  redirect_valid  in   1       redirect request from execute
//  redirect_pc     in   32      redirect target byte address
//  if_valid        out  1       FIFO head is valid for decode
//  if_instr        out  32      instruction at FIFO head
//  if_pc           out  32      byte PC of if_instr
//  id_ready        in   1       decode accepts the head this cycle
// BEHAVIOUR
//  Reset (async, no clock edge required):
//   - pc = RESET_PC, FIFO empty, count = 0.
//   - if_valid = 0, if_instr = 0, if_pc = 0.
//   - Reset asserted mid-stream discards all buffered entries.
//  mem_addr: combinational from pc. It is stable while pc is held.
//   - pc above 4*2^ADDR_W aliases modulo the memory size.
//  pop  = if_valid & id_ready.
//  push = fetch_en & ~redirect_valid & (count < FIFO_DEPTH | pop).
//  On push, at the clock edge:
//   - {pc, mem_data} is written at the FIFO tail.
//   - pc <= pc + 4, with 32-bit wrap-around.
//  Latency: a word fetched at edge N is on if_instr after edge N, i.e. one cycle.
//   - Sustained rate is 1 instr/cycle while id_ready = 1.
//  Full FIFO with pop: push and pop happen together and count is unchanged.
//   - Full FIFO without pop: no push and pc holds.
//  Empty FIFO: if_valid = 0 and if_instr/if_pc = 0. A push and a pop in the
//   same cycle on an empty FIFO is impossible, because if_valid = 0.
//  Outputs come from the FIFO head registers, so there is no combinational
//   path mem_data -> if_instr.
//   - Only the if_valid gate below is combinational.
//  if_valid = head_valid & ~redirect_valid.
//   - Decode never accepts a wrong-path instruction in a redirect cycle.
//  Redirect (redirect_valid = 1), at the clock edge:
//   - The whole FIFO is flushed: count = 0, head/tail = 0.
//   - pc <= {redirect_pc[31:2], 2'b00}; misaligned low bits are dropped.
//   - No push and no pop take effect that edge; the redirect wins over both.
//   - A redirect is honoured even when fetch_en = 0.
//  Back-to-back redirects: the last one wins. The first word from the target
//   is on if_instr two edges after the redirect cycle begins.
//  FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
//   - count is log2(FIFO_DEPTH)+1 bits wide.
// TESTING
//  T1 Fill mem[i] = 32'hA000_0000+i, reset, fetch_en = 1, id_ready = 1.
//     -> From cycle 1, if_pc = 0,4,8,... and if_instr = A0000000,A0000001,...
//     -> One instruction per cycle, no gaps.
//  T2 id_ready = 0 for 4 cycles after reset.
//     -> count = 2, pc holds at 0x08, mem_addr = 2.
//     -> Release: the stream is 0,1,2,3 in order, with no loss or duplicates.
//  T3 FIFO full, redirect_valid = 1 with redirect_pc = 0x40.
//     -> if_valid = 0 during that cycle and the next.
//     -> Then if_pc = 0x40 and if_instr = A0000010.
//  T4 redirect_pc = 0x1FE.
//     -> pc = 0x1FC, mem_addr = 127, if_instr = A000007F.
//     -> Next: if_pc = 0x200, mem_addr = 0, if_instr = A0000000 (alias wrap).
//  T5 Assert reset between clock edges mid-stream.
//     -> if_valid = if_instr = if_pc = 0 immediately.
//     -> After release, the first if_pc = RESET_PC.
//  T6 fetch_en = 0 with 2 entries buffered and id_ready = 1.
//     -> Both entries drain, then if_valid = 0.
//     -> pc and mem_addr stay constant throughout.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the instruction memory and buffers
// {pc, instr} pairs for decode behind a valid/ready handshake.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          ADDR_W     = 7,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  input  logic              id_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH = FIFO_DEPTH[PW:0];

  logic [31:0] pc;
  logic [31:0] pc_q    [FIFO_DEPTH];
  logic [31:0] instr_q [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   count;
  logic head_valid;
  logic pop;
  logic push;

  assign mem_addr   = pc[ADDR_W+1:2];
  assign head_valid = (count != '0);
  assign if_valid   = head_valid & ~redirect_valid;
  assign if_instr   = head_valid ? instr_q[head] : 32'h0;
  assign if_pc      = head_valid ? pc_q[head] : 32'h0;

  assign pop  = if_valid & id_ready;
  assign push = fetch_en & ~redirect_valid
              & ((count < DEPTH) | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      // redirect flushes everything and beats push/pop
      pc    <= {redirect_pc[31:2], 2'b00};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc   <= pc + 32'd4;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_q[i]    <= 32'h0;
        instr_q[i] <= 32'h0;
      end
    end else if (push) begin
      pc_q[tail]    <= pc;
      instr_q[tail] <= mem_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit with a
// queue-based fetch model and mem[i] = A000_0000 + i.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b0;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  logic [31:0] mem [128];
  logic [31:0] mpc;
  logic [63:0] sbq [$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  instr_fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .fetch_en(fetch_en),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .id_ready(id_ready)
  );

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic logic [31:0] word_at(logic [31:0] p);
    return 32'hA000_0000 + ((p >> 2) % 128);
  endfunction

  // monitor: checks handshake and pops the scoreboard on accept
  always @(negedge clk) begin
    logic ev;
    logic [63:0] e;
    if (!reset) begin
      ev = (sbq.size() != 0) && !redirect_valid;
      chk("if_valid", {31'b0, if_valid}, {31'b0, ev});
      chk("mem_addr", {25'b0, mem_addr}, (mpc >> 2) % 128);
      if (sbq.size() == 0) begin
        chk("empty_pc", if_pc, 32'h0);
        chk("empty_instr", if_instr, 32'h0);
      end
      if (ev && id_ready) begin
        e = sbq.pop_front();
        chk("if_pc", if_pc, e[63:32]);
        chk("if_instr", if_instr, e[31:0]);
      end
    end
  end

  // one clock: update the model with the inputs held this cycle
  task automatic cycle(int n = 1);
    repeat (n) begin
      @(posedge clk);
      if (!reset) begin
        if (redirect_valid) begin
          sbq.delete();
          mpc = {redirect_pc[31:2], 2'b00};
        end else if (fetch_en && sbq.size() < 2) begin
          sbq.push_back({mpc, word_at(mpc)});
          mpc = mpc + 32'd4;
        end
      end
      #1;
    end
  endtask

  // assert reset between edges, check at once, release later
  task automatic do_reset();
    #1 reset = 1'b1;
    #1;
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_addr", {25'b0, mem_addr}, 32'h0);
    sbq.delete();
    mpc = 32'h0;
    cycle();
    #1 reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 + i;
    mpc = 32'h0;
    #1;
    do_reset();

    // T1 streaming
    fetch_en = 1'b1;
    id_ready = 1'b1;
    cycle(10);

    // T2 stall then release
    do_reset();
    fetch_en = 1'b1;
    id_ready = 1'b0;
    cycle(4);
    chk("t2_addr", {25'b0, mem_addr}, 32'd2);
    chk("t2_head", if_pc, 32'h0);
    id_ready = 1'b1;
    cycle(6);

    // T3 redirect on full FIFO
    id_ready = 1'b0;
    cycle(3);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    cycle();
    chk("t3_head_pc", if_pc, 32'h40);
    chk("t3_head_instr", if_instr, 32'hA000_0010);
    cycle(3);

    // T4 misaligned target and address alias
    redirect_valid = 1'b1;
    redirect_pc = 32'h1FE;
    cycle();
    redirect_valid = 1'b0;
    chk("t4_addr", {25'b0, mem_addr}, 32'd127);
    cycle(4);

    // T5 reset mid-stream
    do_reset();
    cycle(4);

    // T6 drain with fetch disabled
    do_reset();
    id_ready = 1'b0;
    fetch_en = 1'b1;
    cycle(2);
    fetch_en = 1'b0;
    id_ready = 1'b1;
    cycle(4);
    chk("t6_addr", {25'b0, mem_addr}, 32'd2);

    // random phase
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        fetch_en = ($urandom_range(3) != 0);
        id_ready = ($urandom_range(2) != 0);
        redirect_valid = ($urandom_range(9) == 0);
        redirect_pc = $urandom();
        cycle();
      end
    end

    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    id_ready = 1'b1;
    cycle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
